// File: rtl/alu_mult_sequencer.sv
// Tap scheduler for the dual-lane sfixed multiply stage (int8 x Q0.7).
// Optional ALU_SEQ_OVF_STICKY_EN adds the ovf_sticky overflow flag.
module alu_mult_sequencer #(
  parameter int BUS_WIDTH = 8,
  parameter int NUM_TAPS  = 4,
  parameter int IDX_WIDTH = 3,
  parameter int ACC_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        abort,
  output logic [IDX_WIDTH:0]          coeff_addr,
  output logic                        b_en,
  output logic                        d_en,
  output logic [IDX_WIDTH-1:0]        pair_idx,
  input  logic signed [BUS_WIDTH-1:0] mult_a,
  input  logic signed [BUS_WIDTH-1:0] mult_b,
  output logic                        busy,
  output logic [BUS_WIDTH-1:0]        result,
  output logic                        result_valid,
  output logic                        sat
`ifdef ALU_SEQ_OVF_STICKY_EN
  ,
  output logic                        ovf_sticky
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_B,
    S_LOAD_D,
    S_MULT,
    S_DONE
  } state_t;

  localparam int LP_EXT = ACC_WIDTH - BUS_WIDTH;

  localparam logic signed [ACC_WIDTH-1:0] LP_MAX =
    {{(LP_EXT+1){1'b0}}, {(BUS_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] LP_MIN =
    {{(LP_EXT+1){1'b1}}, {(BUS_WIDTH-1){1'b0}}};

  localparam logic [IDX_WIDTH-1:0] LP_LAST =
    IDX_WIDTH'(NUM_TAPS - 1);

  state_t                        r_state;
  state_t                        w_next;
  logic [IDX_WIDTH-1:0]          r_k;
  logic signed [ACC_WIDTH-1:0]   r_acc;
  logic signed [ACC_WIDTH-1:0]   w_acc_nxt;
  logic [BUS_WIDTH-1:0]          r_result;
  logic                          r_sat;
  logic [BUS_WIDTH-1:0]          w_sat_val;
  logic                          w_sat_hit;
  logic                          w_last;
  logic                          w_accept;

  assign w_last   = (r_k == LP_LAST);
  assign w_accept = (r_state == S_IDLE) && start && !abort;

  // Both lane products, sign-extended, added to the running sum.
  assign w_acc_nxt = r_acc
    + {{LP_EXT{mult_a[BUS_WIDTH-1]}}, mult_a}
    + {{LP_EXT{mult_b[BUS_WIDTH-1]}}, mult_b};

  // Clip the final sum into the signed BUS_WIDTH range.
  always_comb begin
    w_sat_val = w_acc_nxt[BUS_WIDTH-1:0];
    w_sat_hit = 1'b0;
    if (w_acc_nxt > LP_MAX) begin
      w_sat_val = LP_MAX[BUS_WIDTH-1:0];
      w_sat_hit = 1'b1;
    end else if (w_acc_nxt < LP_MIN) begin
      w_sat_val = LP_MIN[BUS_WIDTH-1:0];
      w_sat_hit = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic and Moore outputs.
  always_comb begin
    w_next       = r_state;
    coeff_addr   = '0;
    pair_idx     = '0;
    b_en         = 1'b0;
    d_en         = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_accept) w_next = S_LOAD_B;
      end
      S_LOAD_B: begin
        coeff_addr = {r_k, 1'b0};
        b_en       = 1'b1;
        w_next     = abort ? S_IDLE : S_LOAD_D;
      end
      S_LOAD_D: begin
        coeff_addr = {r_k, 1'b1};
        d_en       = 1'b1;
        w_next     = abort ? S_IDLE : S_MULT;
      end
      S_MULT: begin
        pair_idx = r_k;
        if (abort)       w_next = S_IDLE;
        else if (w_last) w_next = S_DONE;
        else             w_next = S_LOAD_B;
      end
      S_DONE: begin
        result_valid = 1'b1;
        w_next       = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Tap counter and accumulator; cleared in IDLE and on abort.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (r_state == S_IDLE || abort) begin
      r_k   <= '0;
      r_acc <= '0;
    end else if (r_state == S_MULT) begin
      r_acc <= w_acc_nxt;
      r_k   <= w_last ? '0 : r_k + 1'b1;
    end
  end

  // Result captured on the final MULT edge so it is valid in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_sat    <= 1'b0;
    end else if (r_state == S_MULT && w_last && !abort) begin
      r_result <= w_sat_val;
      r_sat    <= w_sat_hit;
    end
  end

  assign result = r_result;
  assign sat    = r_sat;

`ifdef ALU_SEQ_OVF_STICKY_EN
  logic r_ovf;

  // Sticky overflow: set by a clipped result, cleared by a new run.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        r_ovf <= 1'b0;
    else if (w_accept)                 r_ovf <= 1'b0;
    else if (r_state == S_DONE && r_sat) r_ovf <= 1'b1;
  end

  assign ovf_sticky = r_ovf;
`endif

endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed testbench for alu_mult_sequencer with a model of
// the coefficient ROM, sample buffer and sfixed multiply stage.
module tb_alu_mult_sequencer;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [3:0]        coeff_addr;
  logic              b_en, d_en;
  logic [2:0]        pair_idx;
  logic signed [7:0] mult_a, mult_b;
  logic              busy;
  logic [7:0]        result;
  logic              result_valid;
  logic              sat;
`ifdef ALU_SEQ_OVF_STICKY_EN
  logic              ovf_sticky;
`endif

  int errors = 0;
  int checks = 0;

  logic signed [7:0] xs [16];
  logic signed [7:0] coef [16];
  logic signed [7:0] r_b = 0;
  logic signed [7:0] r_d = 0;

  alu_mult_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .coeff_addr   (coeff_addr),
    .b_en         (b_en),
    .d_en         (d_en),
    .pair_idx     (pair_idx),
    .mult_a       (mult_a),
    .mult_b       (mult_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .sat          (sat)
`ifdef ALU_SEQ_OVF_STICKY_EN
    ,
    .ovf_sticky   (ovf_sticky)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic signed [7:0] qmul(
    input logic signed [7:0] x, input logic signed [7:0] c);
    logic signed [15:0] p;
    p = x * c;
    return p[14:7];
  endfunction

  always @(posedge clk) begin
    if (b_en) r_b <= coef[coeff_addr];
    if (d_en) r_d <= coef[coeff_addr];
  end

  assign mult_a = qmul(xs[{pair_idx, 1'b0}], r_b);
  assign mult_b = qmul(xs[{pair_idx, 1'b1}], r_d);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int base, input int step,
                          input logic [7:0] c);
    for (int i = 0; i < 16; i++) begin
      xs[i]   = 8'(base + step * i);
      coef[i] = c;
    end
  endtask

  task automatic run_one(output int lat, output logic [7:0] res,
                         output logic s);
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 1;
    while (!result_valid && lat < 40) begin
      tick();
      lat++;
    end
    res = result;
    s   = sat;
    tick();
  endtask

  task automatic test_reset();
    #3;
    checks++;
    if ({busy, result_valid, sat, b_en, d_en} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctl got=%b want=00000",
               {busy, result_valid, sat, b_en, d_en});
    end
    checks++;
    if ({result, coeff_addr, pair_idx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_bus res=%h addr=%h idx=%h want 0",
               result, coeff_addr, pair_idx);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat; logic [7:0] r; logic s;
    set_data(2, 2, 8'h40);
    run_one(lat, r, s);
    checks++;
    if (lat !== 13) begin
      errors++;
      $display("FAIL t1_latency got=%0d want=13", lat);
    end
    checks++;
    if (r !== 8'h24 || s !== 1'b0) begin
      errors++;
      $display("FAIL t1_result got=%h/%b want=24/0", r, s);
    end
    checks++;
    if (result !== 8'h24 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t1_hold res=%h busy=%b want 24/0", result, busy);
    end
  endtask

  task automatic test_sat_pos();
    int lat; logic [7:0] r; logic s;
    set_data(10, 10, 8'h40);
    run_one(lat, r, s);
    checks++;
    if (r !== 8'h7F || s !== 1'b1) begin
      errors++;
      $display("FAIL t2_clip_hi got=%h/%b want=7f/1", r, s);
    end
`ifdef ALU_SEQ_OVF_STICKY_EN
    checks++;
    if (ovf_sticky !== 1'b1) begin
      errors++;
      $display("FAIL t2_sticky got=%b want=1", ovf_sticky);
    end
`endif
  endtask

  task automatic test_sat_neg();
    int lat; logic [7:0] r; logic s;
    set_data(-128, 0, 8'h7F);
    run_one(lat, r, s);
    checks++;
    if (r !== 8'h80 || s !== 1'b1) begin
      errors++;
      $display("FAIL t3_clip_lo got=%h/%b want=80/1", r, s);
    end
  endtask

  task automatic test_abort();
    int lat; logic [7:0] r; logic s;
    bit seen;
    set_data(10, 10, 8'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    checks++;
    if (d_en !== 1'b1 || coeff_addr !== 4'd3) begin
      errors++;
      $display("FAIL t4_ld2 d_en=%b addr=%0d want 1/3",
               d_en, coeff_addr);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0 || result !== 8'h80 || sat !== 1'b1) begin
      errors++;
      $display("FAIL t4_abort busy=%b res=%h sat=%b want 0/80/1",
               busy, result, sat);
    end
    seen = 0;
    repeat (16) begin
      if (result_valid) seen = 1;
      tick();
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL t4_no_valid got=%b want=0", seen);
    end
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL t4_start_abort busy=%b want=0", busy);
    end
    set_data(2, 2, 8'h40);
    run_one(lat, r, s);
    checks++;
    if (r !== 8'h24 || s !== 1'b0) begin
      errors++;
      $display("FAIL t4_fresh got=%h/%b want=24/0", r, s);
    end
  endtask

  task automatic test_back_to_back();
    int addrs[$];
    int rvs[$];
    bit overlap, bad_en, bad_res;
    int n;
    overlap = 0; bad_en = 0; bad_res = 0;
    set_data(2, 2, 8'h40);
    start = 1'b1;
    for (int cyc = 1; cyc <= 45; cyc++) begin
      tick();
      if (b_en && d_en) overlap = 1;
      if ((b_en || d_en) && rvs.size() == 0) begin
        addrs.push_back(int'(coeff_addr));
        if (b_en !== ~coeff_addr[0]) bad_en = 1;
      end
      if (result_valid) begin
        rvs.push_back(cyc);
        if (result !== 8'h24) bad_res = 1;
      end
    end
    start = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (overlap !== 1'b0 || bad_en !== 1'b0) begin
      errors++;
      $display("FAIL t5_enables overlap=%b bad=%b want 0/0",
               overlap, bad_en);
    end
    checks++;
    if (addrs.size() != 8) begin
      errors++;
      $display("FAIL t5_addr_cnt got=%0d want=8", addrs.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (addrs[i] != i) begin
          errors++;
          $display("FAIL t5_addr[%0d] got=%0d want=%0d",
                   i, addrs[i], i);
        end
      end
    end
    checks++;
    if (rvs.size() != 3) begin
      errors++;
      $display("FAIL t5_valid_cnt got=%0d want=3", rvs.size());
    end else begin
      checks++;
      if (rvs[0] != 13 || rvs[1] != 27 || rvs[2] != 41) begin
        errors++;
        $display("FAIL t5_period got=%0d,%0d,%0d want=13,27,41",
                 rvs[0], rvs[1], rvs[2]);
      end
    end
    checks++;
    if (bad_res !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL t5_tail badres=%b busy=%b want 0/0",
               bad_res, busy);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [7:0] r; logic s;
    set_data(2, 2, 8'h40);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (2) tick();
    checks++;
    if (pair_idx !== 3'd0 || busy !== 1'b1 || b_en || d_en) begin
      errors++;
      $display("FAIL t6_in_mult idx=%0d busy=%b want 0/1",
               pair_idx, busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, result_valid, sat, b_en, d_en} !== 5'b0 ||
        result !== 8'h00) begin
      errors++;
      $display("FAIL t6_async ctl=%b res=%h want 00000/00",
               {busy, result_valid, sat, b_en, d_en}, result);
    end
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    run_one(lat, r, s);
    checks++;
    if (r !== 8'h24 || s !== 1'b0 || lat !== 13) begin
      errors++;
      $display("FAIL t6_restart got=%h/%b lat=%0d want=24/0 13",
               r, s, lat);
    end
  endtask

  initial begin
    set_data(0, 0, 8'h00);
    test_reset();
    test_basic();
    test_sat_pos();
    test_sat_neg();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
